// File: rtl/dm_pkg.sv
`timescale 1ns/1ps
// Shared types and widths for the data-memory block mover.
package dm_pkg;

    localparam int unsigned DM_AW = 8;
    localparam int unsigned DM_DW = 8;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dm_state_t;

endpackage

// File: rtl/dm_block_mover.sv
`timescale 1ns/1ps
// Block copy / fill initiator for the 256x8 data memory; reports an 8-bit
// additive checksum of every byte written in the current transfer.
module dm_block_mover
    import dm_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start_in,
    input  logic             mode_in,
    input  logic [DM_AW-1:0] src_in,
    input  logic [DM_AW-1:0] dst_in,
    input  logic [DM_AW-1:0] len_in,
    input  logic [DM_DW-1:0] fill_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [DM_DW-1:0] checksum_out,
    output logic [DM_AW-1:0] mem_addr_out,
    output logic [DM_DW-1:0] mem_data_out,
    output logic             mem_write_out,
    input  logic [DM_DW-1:0] mem_rdata_in
);

    dm_state_t        state, state_d;
    logic [DM_AW-1:0] src_q, src_d;
    logic [DM_AW-1:0] dst_q, dst_d;
    logic [DM_AW-1:0] rem_q, rem_d;
    logic [DM_DW-1:0] data_q, data_d;
    logic [DM_DW-1:0] fill_q, fill_d;
    logic [DM_DW-1:0] sum_d;
    logic             mode_q, mode_d;
    logic [DM_DW-1:0] wbyte;
    logic             busy_d, done_d, write_d;
    logic [DM_AW-1:0] addr_d;
    logic [DM_DW-1:0] wdata_d;

    // State register, pointers, and registered memory-side outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            rem_q         <= '0;
            data_q        <= '0;
            fill_q        <= '0;
            mode_q        <= MODE_COPY;
            checksum_out  <= '0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            mem_addr_out  <= '0;
            mem_data_out  <= '0;
            mem_write_out <= 1'b0;
        end else begin
            state         <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            rem_q         <= rem_d;
            data_q        <= data_d;
            fill_q        <= fill_d;
            mode_q        <= mode_d;
            checksum_out  <= sum_d;
            busy_out      <= busy_d;
            done_out      <= done_d;
            mem_addr_out  <= addr_d;
            mem_data_out  <= wdata_d;
            mem_write_out <= write_d;
        end
    end

    assign wbyte = (mode_q == MODE_FILL) ? fill_q : data_q;

    // Next-state logic; outputs are decoded from the next state so they
    // line up with the state they describe once registered.
    always_comb begin
        state_d = state;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        fill_d  = fill_q;
        mode_d  = mode_q;
        sum_d   = checksum_out;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        write_d = 1'b0;
        addr_d  = '0;
        wdata_d = '0;

        unique case (state)
            IDLE: begin
                if (start_in) begin
                    src_d  = src_in;
                    dst_d  = dst_in;
                    rem_d  = len_in;
                    fill_d = fill_in;
                    mode_d = mode_in;
                    sum_d  = '0;
                    if (len_in == '0)
                        state_d = DONE;
                    else if (mode_in == MODE_FILL)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                data_d  = mem_rdata_in;
                state_d = WRITE;
            end
            WRITE: begin
                sum_d = DM_DW'(checksum_out + wbyte);
                src_d = DM_AW'(src_q + DM_AW'(1));
                dst_d = DM_AW'(dst_q + DM_AW'(1));
                rem_d = DM_AW'(rem_q - DM_AW'(1));
                if (rem_q == DM_AW'(1))
                    state_d = DONE;
                else if (mode_q == MODE_COPY)
                    state_d = READ;
                else
                    state_d = WRITE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d == READ) || (state_d == WRITE);
        done_d  = (state_d == DONE);
        write_d = (state_d == WRITE);
        if (state_d == READ)
            addr_d = src_d;
        else if (state_d == WRITE)
            addr_d = dst_d;
        if (state_d == WRITE)
            wdata_d = (mode_d == MODE_FILL) ? fill_d : data_d;
    end

endmodule

// File: tb/tb_dm_block_mover.sv
`timescale 1ns/1ps
// Scoreboard bench for dm_block_mover with a behavioural 256x8 data memory.
module tb_dm_block_mover;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       start_in = 1'b0;
    logic       mode_in = 1'b0;
    logic [7:0] src_in = '0, dst_in = '0, len_in = '0, fill_in = '0;
    logic       busy_out, done_out, mem_write_out;
    logic [7:0] checksum_out, mem_addr_out, mem_data_out, mem_rdata_in;

    logic [7:0] mem [256];

    typedef struct {
        int chk;
        int cyc;
        int busy;
        int wr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   wr_cnt = 0;
    int   done_seen = 0;

    dm_block_mover dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .start_in     (start_in),
        .mode_in      (mode_in),
        .src_in       (src_in),
        .dst_in       (dst_in),
        .len_in       (len_in),
        .fill_in      (fill_in),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .checksum_out (checksum_out),
        .mem_addr_out (mem_addr_out),
        .mem_data_out (mem_data_out),
        .mem_write_out(mem_write_out),
        .mem_rdata_in (mem_rdata_in)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Data memory: combinational read, write commits on the rising edge.
    assign mem_rdata_in = mem[mem_addr_out];
    always @(posedge CLK) if (mem_write_out) mem[mem_addr_out] <= mem_data_out;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: counts busy/write cycles and scores each done pulse.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            busy_cnt = 0;
            wr_cnt   = 0;
        end else begin
            if (busy_out) busy_cnt++;
            if (mem_write_out) wr_cnt++;
            if (done_out) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc + 1, e.cyc);
                    check("checksum", int'(checksum_out), e.chk);
                    check("busy_cycles", busy_cnt, e.busy);
                    check("write_pulses", wr_cnt, e.wr);
                end
                busy_cnt = 0;
                wr_cnt   = 0;
                done_seen++;
            end
        end
    end

    task automatic run(input bit mode, input logic [7:0] src, input logic [7:0] dst,
                       input logic [7:0] len, input logic [7:0] fill,
                       input int echk, input bit repulse);
        exp_t e;
        int   k;
        int   prev;
        @(negedge CLK);
        prev   = done_seen;
        k      = cyc + 1;
        e.chk  = echk;
        e.busy = (len == 0) ? 0 : (mode ? int'(len) : 2 * int'(len));
        e.wr   = int'(len);
        e.cyc  = k + e.busy + 1;
        sb.push_back(e);
        mode_in = mode; src_in = src; dst_in = dst; len_in = len; fill_in = fill;
        start_in = 1'b1;
        @(posedge CLK);
        #1 start_in = 1'b0;
        if (repulse) begin
            @(negedge CLK);
            @(negedge CLK);
            mode_in = ~mode; dst_in = 8'(dst + 8'd5); len_in = 8'd9; fill_in = 8'hFF;
            start_in = 1'b1;
            @(posedge CLK);
            #1 start_in = 1'b0;
        end
        for (int t = 0; t < 600 && done_seen == prev; t++) @(negedge CLK);
        if (done_seen == prev) check("done_timeout", 0, 1);
        @(negedge CLK);
        @(negedge CLK);
        check("checksum_hold", int'(checksum_out), echk);
        check("idle_after_done", int'({busy_out, done_out, mem_write_out}), 0);
    endtask

    initial begin
        int prev;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        #12;
        check("rst_busy", int'(busy_out), 0);
        check("rst_done", int'(done_out), 0);
        check("rst_checksum", int'(checksum_out), 0);
        check("rst_addr", int'(mem_addr_out), 0);
        check("rst_wdata", int'(mem_data_out), 0);
        check("rst_write", int'(mem_write_out), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Copy 3 bytes
        mem[10] = 8'd5; mem[11] = 8'd6; mem[12] = 8'd7;
        run(1'b0, 8'd10, 8'd40, 8'd3, 8'd0, 18, 1'b0);
        check("copy_m40", int'(mem[40]), 5);
        check("copy_m41", int'(mem[41]), 6);
        check("copy_m42", int'(mem[42]), 7);

        // Empty transfer clears the previous checksum
        run(1'b0, 8'd10, 8'd50, 8'd0, 8'd0, 0, 1'b0);
        check("empty_m50", int'(mem[50]), 0);

        // Fill 4 bytes of 0xAA
        run(1'b1, 8'd0, 8'd100, 8'd4, 8'hAA, 8'hA8, 1'b0);
        for (int i = 100; i < 104; i++) check("fill_byte", int'(mem[i]), 8'hAA);
        check("fill_m104", int'(mem[104]), 0);

        // Fill wrapping past address 255
        mem[1] = 8'h77;
        run(1'b1, 8'd0, 8'd254, 8'd3, 8'd1, 3, 1'b0);
        check("wrap_m254", int'(mem[254]), 1);
        check("wrap_m255", int'(mem[255]), 1);
        check("wrap_m0", int'(mem[0]), 1);
        check("wrap_m1", int'(mem[1]), 8'h77);

        // Forward overlapping copy propagates the first byte
        mem[20] = 8'd1; mem[21] = 8'd2; mem[22] = 8'd3; mem[23] = 8'd4;
        run(1'b0, 8'd20, 8'd21, 8'd3, 8'd0, 3, 1'b0);
        check("ovl_m20", int'(mem[20]), 1);
        check("ovl_m21", int'(mem[21]), 1);
        check("ovl_m22", int'(mem[22]), 1);
        check("ovl_m23", int'(mem[23]), 1);

        // start re-pulsed while busy is ignored
        mem[60] = 8'd9; mem[61] = 8'd8; mem[72] = 8'h3C;
        run(1'b0, 8'd60, 8'd70, 8'd2, 8'd0, 17, 1'b1);
        check("rep_m70", int'(mem[70]), 9);
        check("rep_m71", int'(mem[71]), 8);
        check("rep_m72", int'(mem[72]), 8'h3C);
        check("rep_m75", int'(mem[75]), 0);

        // Reset during the second WRITE of a 4-byte fill
        @(negedge CLK);
        prev = done_seen;
        mode_in = 1'b1; dst_in = 8'd200; len_in = 8'd4; fill_in = 8'h55;
        start_in = 1'b1;
        @(posedge CLK);
        #1 start_in = 1'b0;
        @(posedge CLK);
        #2 check("mid_write_before_rst", int'(mem_write_out), 1);
        RST_N = 1'b0;
        #1 check("mid_write_async_drop", int'(mem_write_out), 0);
        @(posedge CLK);
        #1;
        check("mid_m200", int'(mem[200]), 8'h55);
        check("mid_m201", int'(mem[201]), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("post_busy", int'(busy_out), 0);
        check("post_done", int'(done_out), 0);
        check("post_checksum", int'(checksum_out), 0);
        check("post_addr", int'(mem_addr_out), 0);
        check("post_wdata", int'(mem_data_out), 0);
        check("post_write", int'(mem_write_out), 0);
        repeat (8) @(negedge CLK);
        check("post_no_done", done_seen, prev);
        check("post_m202", int'(mem[202]), 0);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
